// File: rtl/shield_step_arbiter_pkg.sv
// Shared types, widths and helpers for the shield step arbiter.
// Optional per-agent override statistics: SHIELD_ARB_AGENT_STATS_EN.
package shield_arb_pkg;

  typedef enum logic [0:0] {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } arb_state_e;

  localparam int unsigned LIGHT_W = 3;
  localparam logic [LIGHT_W-1:0] HOLD_RESET = 3'b000;

  // Increment v, holding at the all-ones value of a w-bit counter
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/shield_step_arbiter_if.sv
// Bus bundle between the agents, the arbiter, the shield and the downstream consumer.
// Optional per-agent override statistics: SHIELD_ARB_AGENT_STATS_EN.
interface shield_arb_if #(
  parameter int unsigned N_AGENTS = 4,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned CNT_W    = 16
);
  import shield_arb_pkg::*;

  logic                          u1;
  logic [N_AGENTS-1:0]           agent_valid;
  logic [LIGHT_W*N_AGENTS-1:0]   agent_l;
  logic [N_AGENTS-1:0]           agent_ready;
  logic                          sh_u1;
  logic [LIGHT_W-1:0]            sh_l;
  logic [LIGHT_W-1:0]            sh_l_corr;
  logic                          act_valid;
  logic [LIGHT_W-1:0]            act_l;
  logic [IDX_W-1:0]              act_agent;
  logic                          act_override;
  logic [CNT_W-1:0]              override_cnt;
`ifdef SHIELD_ARB_AGENT_STATS_EN
  logic [N_AGENTS*CNT_W-1:0]     agent_ovr_cnt;
`endif

  // Arbiter side
  modport master (
    input  u1, agent_valid, agent_l, sh_l_corr,
    output agent_ready, sh_u1, sh_l, act_valid, act_l, act_agent, act_override,
           override_cnt
`ifdef SHIELD_ARB_AGENT_STATS_EN
    , output agent_ovr_cnt
`endif
  );

  // Agents, shield and consumer side
  modport slave (
    output u1, agent_valid, agent_l, sh_l_corr,
    input  agent_ready, sh_u1, sh_l, act_valid, act_l, act_agent, act_override,
           override_cnt
`ifdef SHIELD_ARB_AGENT_STATS_EN
    , input agent_ovr_cnt
`endif
  );

endinterface

// File: rtl/shield_step_arbiter_rr_pick.sv
// Rotating-priority one-hot picker: first valid at or after ptr, modulo N.
module shield_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from farthest to nearest so the entry closest to ptr wins
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= int'(N)) j = j - int'(N);
      if (valid[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shield_step_arbiter.sv
// Shares one 3-light safety shield among N_AGENTS proposers, one grant per plant step.
// Optional per-agent override statistics: SHIELD_ARB_AGENT_STATS_EN.
module shield_step_arbiter
  import shield_arb_pkg::*;
#(
  parameter int unsigned N_AGENTS   = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WARMUP_CYC = 4
) (
  input  logic         clock,
  input  logic         reset,
  shield_arb_if.master bus
);

  localparam int unsigned WARM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_AGENTS - 1);

  arb_state_e           state_q, state_d;
  logic [WARM_W-1:0]    warm_cnt_q, warm_cnt_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [LIGHT_W-1:0]   hold_q, hold_d;
  logic                 act_valid_q, act_valid_d;
  logic [LIGHT_W-1:0]   act_l_q, act_l_d;
  logic [IDX_W-1:0]     act_agent_q, act_agent_d;
  logic                 act_override_q, act_override_d;
  logic [CNT_W-1:0]     ovr_cnt_q, ovr_cnt_d;

  logic [N_AGENTS-1:0]  pick_grant;
  logic [IDX_W-1:0]     win_idx;
  logic                 pick_any;
  logic [N_AGENTS-1:0]  grant_c;
  logic [LIGHT_W-1:0]   sh_l_c;
  logic [LIGHT_W-1:0]   prop_c;
  logic                 ovr_now_c;

  shield_rr_pick #(
    .N     (N_AGENTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid (bus.agent_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (win_idx),
    .any   (pick_any)
  );

  assign prop_c = bus.agent_l[LIGHT_W*int'(win_idx) +: LIGHT_W];

  // Next state, grant, shield drive and action capture
  always_comb begin
    state_d        = state_q;
    warm_cnt_d     = warm_cnt_q;
    ptr_d          = ptr_q;
    hold_d         = hold_q;
    act_valid_d    = 1'b0;
    act_l_d        = act_l_q;
    act_agent_d    = act_agent_q;
    act_override_d = act_override_q;
    ovr_cnt_d      = ovr_cnt_q;
    grant_c        = '0;
    sh_l_c         = hold_q;
    ovr_now_c      = 1'b0;

    unique case (state_q)
      WARMUP: begin
        if (warm_cnt_q == WARM_LAST) begin
          state_d    = RUN;
          warm_cnt_d = '0;
        end else begin
          warm_cnt_d = warm_cnt_q + WARM_W'(1);
        end
      end
      RUN: begin
        if (pick_any && !reset) begin
          grant_c        = pick_grant;
          sh_l_c         = prop_c;
          ptr_d          = (win_idx == IDX_LAST) ? '0 : (win_idx + IDX_W'(1));
          ovr_now_c      = (bus.sh_l_corr != prop_c);
          act_valid_d    = 1'b1;
          act_l_d        = bus.sh_l_corr;
          act_agent_d    = win_idx;
          act_override_d = ovr_now_c;
          hold_d         = bus.sh_l_corr;
          if (ovr_now_c) ovr_cnt_d = CNT_W'(sat_inc(32'(ovr_cnt_q), CNT_W));
        end
      end
      default: state_d = WARMUP;
    endcase
  end

  // State and action registers; reset overrides everything
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= WARMUP;
      warm_cnt_q     <= '0;
      ptr_q          <= '0;
      hold_q         <= HOLD_RESET;
      act_valid_q    <= 1'b0;
      act_l_q        <= '0;
      act_agent_q    <= '0;
      act_override_q <= 1'b0;
      ovr_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      warm_cnt_q     <= warm_cnt_d;
      ptr_q          <= ptr_d;
      hold_q         <= hold_d;
      act_valid_q    <= act_valid_d;
      act_l_q        <= act_l_d;
      act_agent_q    <= act_agent_d;
      act_override_q <= act_override_d;
      ovr_cnt_q      <= ovr_cnt_d;
    end
  end

  assign bus.agent_ready  = grant_c;
  assign bus.sh_u1        = bus.u1;
  assign bus.sh_l         = sh_l_c;
  assign bus.act_valid    = act_valid_q;
  assign bus.act_l        = act_l_q;
  assign bus.act_agent    = act_agent_q;
  assign bus.act_override = act_override_q;
  assign bus.override_cnt = ovr_cnt_q;

`ifdef SHIELD_ARB_AGENT_STATS_EN
  logic [CNT_W-1:0] agent_cnt_q [N_AGENTS];
  logic [CNT_W-1:0] agent_cnt_d [N_AGENTS];

  // Per-agent saturating override tally
  always_comb begin
    agent_cnt_d = agent_cnt_q;
    if (ovr_now_c) agent_cnt_d[win_idx] = CNT_W'(sat_inc(32'(agent_cnt_q[win_idx]), CNT_W));
  end

  // Per-agent counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(N_AGENTS); i++) agent_cnt_q[i] <= '0;
    end else begin
      agent_cnt_q <= agent_cnt_d;
    end
  end

  for (genvar g = 0; g < int'(N_AGENTS); g++) begin : g_stats
    assign bus.agent_ovr_cnt[g*CNT_W +: CNT_W] = agent_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_shield_step_arbiter.sv
// Directed bench for shield_step_arbiter: a 16-bit and a 2-bit counter instance share stimulus.
module tb_shield_step_arbiter;
  import shield_arb_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  shield_arb_if #(.N_AGENTS(4), .IDX_W(2), .CNT_W(16)) bus  ();
  shield_arb_if #(.N_AGENTS(4), .IDX_W(2), .CNT_W(2))  bus2 ();

  // Toy shield: u1 forbids l3; l1 and l2 together drop l2
  function automatic logic [2:0] shield_fn(input logic [2:0] l, input logic u);
    return {l[2] & ~u, l[1] & ~l[0], l[0]};
  endfunction

  assign bus.sh_l_corr   = shield_fn(bus.sh_l, bus.u1);
  assign bus2.sh_l_corr  = shield_fn(bus2.sh_l, bus2.u1);
  assign bus2.u1         = bus.u1;
  assign bus2.agent_valid = bus.agent_valid;
  assign bus2.agent_l    = bus.agent_l;

  shield_step_arbiter #(.N_AGENTS(4), .IDX_W(2), .CNT_W(16), .WARMUP_CYC(4)) dut (
    .clock (clock), .reset (reset), .bus (bus)
  );

  shield_step_arbiter #(.N_AGENTS(4), .IDX_W(2), .CNT_W(2), .WARMUP_CYC(4)) dut2 (
    .clock (clock), .reset (reset), .bus (bus2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [3:0] exp_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [2:0] exp_shl   [5] = '{3'b100, 3'b010, 3'b011, 3'b001, 3'b100};
  logic [2:0] exp_act   [5] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b100};
  logic [1:0] exp_agt   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] exp_sat   [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    reset           = 1'b1;
    bus.u1          = 1'b0;
    bus.agent_valid = 4'b1111;
    bus.agent_l     = {3'b001, 3'b011, 3'b010, 3'b100};
    tick();
    tick();
    #1;
    check_eq("rst_act_valid", 32'(bus.act_valid), 32'd0);
    check_eq("rst_act_l", 32'(bus.act_l), 32'd0);
    check_eq("rst_act_agent", 32'(bus.act_agent), 32'd0);
    check_eq("rst_override", 32'(bus.act_override), 32'd0);
    check_eq("rst_cnt", 32'(bus.override_cnt), 32'd0);
    check_eq("rst_ready", 32'(bus.agent_ready), 32'd0);

    // Warmup: four cycles of no grants and hold action 000
    tick();
    reset = 1'b0;
    for (int w = 0; w < 4; w++) begin
      #1;
      check_eq("warm_ready", 32'(bus.agent_ready), 32'd0);
      check_eq("warm_sh_l", 32'(bus.sh_l), 32'd0);
      tick();
    end

    // Round robin over four always-valid agents
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("rr_ready", 32'(bus.agent_ready), 32'(exp_grant[k]));
      check_eq("rr_sh_l", 32'(bus.sh_l), 32'(exp_shl[k]));
      if (k > 0) begin
        check_eq("rr_act_valid", 32'(bus.act_valid), 32'd1);
        check_eq("rr_act_agent", 32'(bus.act_agent), 32'(exp_agt[k-1]));
        check_eq("rr_act_l", 32'(bus.act_l), 32'(exp_act[k-1]));
      end
      if (k == 3) begin
        check_eq("ovr_flag", 32'(bus.act_override), 32'd1);
        check_eq("ovr_cnt", 32'(bus.override_cnt), 32'd1);
      end
      if (k == 4) check_eq("no_ovr_flag", 32'(bus.act_override), 32'd0);
      tick();
    end

    // Only agent 3 valid with ptr=1
    bus.agent_valid = 4'b1000;
    #1;
    check_eq("solo_ready", 32'(bus.agent_ready), 32'b1000);
    check_eq("solo_sh_l", 32'(bus.sh_l), 32'b001);
    tick();
    bus.agent_valid = 4'b0000;
    bus.u1          = 1'b1;
    #1;
    check_eq("idle_ready", 32'(bus.agent_ready), 32'd0);
    check_eq("idle_sh_l_hold", 32'(bus.sh_l), 32'b001);
    check_eq("solo_act_valid", 32'(bus.act_valid), 32'd1);
    check_eq("solo_act_agent", 32'(bus.act_agent), 32'd3);
    check_eq("sh_u1_pass", 32'(bus.sh_u1), 32'd1);
    tick();
    bus.agent_valid = 4'b1111;
    bus.u1          = 1'b0;
    #1;
    check_eq("idle_act_valid", 32'(bus.act_valid), 32'd0);
    check_eq("idle_act_l_kept", 32'(bus.act_l), 32'b001);
    check_eq("idle_act_agent_kept", 32'(bus.act_agent), 32'd3);
    check_eq("ptr_wrap_ready", 32'(bus.agent_ready), 32'b0001);
    check_eq("cnt_kept", 32'(bus.override_cnt), 32'd1);
    tick();

    // Reset on a grant cycle
    reset = 1'b1;
    #1;
    check_eq("rst_grant_ready", 32'(bus.agent_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("post_rst_act_valid", 32'(bus.act_valid), 32'd0);
    check_eq("post_rst_cnt", 32'(bus.override_cnt), 32'd0);
    check_eq("post_rst_sh_l", 32'(bus.sh_l), 32'd0);
    check_eq("post_rst_ready", 32'(bus.agent_ready), 32'd0);
    tick();
    tick();
    tick();
    #1;
    check_eq("rewarm_ready", 32'(bus.agent_ready), 32'd0);
    tick();
    #1;
    check_eq("ptr_reset_ready", 32'(bus.agent_ready), 32'b0001);
    tick();

    // Repeated overrides from agent 2: saturation on the 2-bit counter
    bus.agent_valid = 4'b0100;
    #1;
    check_eq("sat_ready", 32'(bus.agent_ready), 32'b0100);
    for (int r = 0; r < 5; r++) begin
      tick();
      #1;
      check_eq("sat_cnt2", 32'(bus2.override_cnt), 32'(exp_sat[r]));
      check_eq("sat_cnt16", 32'(bus.override_cnt), 32'(r + 1));
      check_eq("sat_flag", 32'(bus.act_override), 32'd1);
    end
    bus.agent_valid = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
